// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types and constants for the ROM fetch arbiter: FSM states, grant
// ownership and the SDRAM word address width.
package rom_fetch_arbiter_pkg;

  localparam int SDR_AW = 25;

  typedef enum logic [1:0] {
    IDLE,
    CPU_FETCH,
    AUX_FETCH
  } rom_arb_state_t;

  typedef enum logic {
    OWNER_CPU,
    OWNER_AUX
  } rom_owner_t;

endpackage

// File: rtl/rom_fetch_arbiter_hit_buffer.sv
// One-word CPU hit buffer: remembers the last CPU fill so a repeated fetch of
// the same word can be answered without touching SDRAM.
module rom_hit_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        fill,
  input  logic [19:0] fill_addr,
  input  logic [15:0] fill_data,
  input  logic        inval,
  input  logic [19:0] cmp_addr,
  output logic        hit,
  output logic [15:0] buf_data
);

  logic [19:0] buf_addr;
  logic        buf_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
    end else if (fill) begin
      buf_addr  <= fill_addr;
      buf_data  <= fill_data;
      // A bank switch racing the fill still leaves the word untrusted.
      buf_valid <= !inval;
    end else if (inval) begin
      buf_valid <= 1'b0;
    end
  end

  assign hit = buf_valid && (buf_addr == cmp_addr);

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates the single SDRAM ROM read channel between the CPU ROM path and
// an auxiliary DMA requester, with round-robin on ties and a CPU hit buffer.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter logic [SDR_AW-1:0] CPU_BASE = 25'h000_0000,
  parameter logic [SDR_AW-1:0] AUX_BASE = 25'h010_0000,
  parameter int                AUX_AW   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [19:0]       cpu_addr,
  output logic [15:0]       cpu_data,
  output logic              cpu_ready,
  input  logic              inval,
  input  logic              aux_req,
  input  logic [AUX_AW-1:0] aux_addr,
  output logic [15:0]       aux_data,
  output logic              aux_ack,
  output logic              sdr_req,
  output logic [SDR_AW-1:0] sdr_addr,
  input  logic              sdr_ack,
  input  logic [15:0]       sdr_data
);

  // Handshake: cpu_req/aux_req are one-cycle strobes accepted only while the
  // requester has nothing pending; sdr_req is a level held with a stable
  // sdr_addr until a one-cycle sdr_ack; cpu_ready/aux_ack are one-cycle pulses.

  rom_arb_state_t    state;
  rom_owner_t        last_owner;
  logic              cpu_pend;
  logic              aux_pend;
  logic [19:0]       cpu_lat;
  logic [AUX_AW-1:0] aux_lat;

  logic        buf_hit;
  logic [15:0] buf_data;
  logic        cpu_hit;
  logic        cpu_miss;
  logic        aux_new;
  logic        cpu_want;
  logic        aux_want;
  logic        grant_cpu;
  logic [19:0]       cpu_eff_addr;
  logic [AUX_AW-1:0] aux_eff_addr;
  logic        fill;

  assign cpu_hit  = cpu_req && !cpu_pend && buf_hit && !inval;
  assign cpu_miss = cpu_req && !cpu_pend && !cpu_hit;
  assign aux_new  = aux_req && !aux_pend;

  // A fresh strobe is folded in so a miss on an idle channel issues at once.
  assign cpu_want     = cpu_pend || cpu_miss;
  assign aux_want     = aux_pend || aux_new;
  assign grant_cpu    = cpu_want && (!aux_want || last_owner == OWNER_AUX);
  assign cpu_eff_addr = cpu_pend ? cpu_lat : cpu_addr;
  assign aux_eff_addr = aux_pend ? aux_lat : aux_addr;
  assign fill         = (state == CPU_FETCH) && sdr_ack;

  rom_hit_buffer u_hit_buffer (
    .clk       (clk),
    .reset     (reset),
    .fill      (fill),
    .fill_addr (cpu_lat),
    .fill_data (sdr_data),
    .inval     (inval),
    .cmp_addr  (cpu_addr),
    .hit       (buf_hit),
    .buf_data  (buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWNER_AUX;
      cpu_pend   <= 1'b0;
      aux_pend   <= 1'b0;
      cpu_lat    <= '0;
      aux_lat    <= '0;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      cpu_ready  <= 1'b0;
      aux_ack    <= 1'b0;
      cpu_data   <= '0;
      aux_data   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      aux_ack   <= 1'b0;

      if (cpu_hit) begin
        cpu_ready <= 1'b1;
        cpu_data  <= buf_data;
      end else if (cpu_miss) begin
        cpu_pend <= 1'b1;
        cpu_lat  <= cpu_addr;
      end
      if (aux_new) begin
        aux_pend <= 1'b1;
        aux_lat  <= aux_addr;
      end

      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state    <= CPU_FETCH;
            sdr_req  <= 1'b1;
            sdr_addr <= CPU_BASE + SDR_AW'(cpu_eff_addr);
          end else if (aux_want) begin
            state    <= AUX_FETCH;
            sdr_req  <= 1'b1;
            sdr_addr <= AUX_BASE + SDR_AW'(aux_eff_addr);
          end
        end
        CPU_FETCH: begin
          if (sdr_ack) begin
            state      <= IDLE;
            sdr_req    <= 1'b0;
            cpu_data   <= sdr_data;
            cpu_ready  <= 1'b1;
            cpu_pend   <= 1'b0;
            last_owner <= OWNER_CPU;
          end
        end
        AUX_FETCH: begin
          if (sdr_ack) begin
            state      <= IDLE;
            sdr_req    <= 1'b0;
            aux_data   <= sdr_data;
            aux_ack    <= 1'b1;
            aux_pend   <= 1'b0;
            last_owner <= OWNER_AUX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares the single SDRAM ROM read channel between the main CPU ROM path (already bank-translated) and an auxiliary requester (sample/sound ROM DMA).
- Keeps a one-word CPU hit buffer so repeated fetches skip SDRAM.
- Drives the CPU wait/ready handshake.
- Sits between the CPU bus decode and the SDRAM controller port.

Parameters:
CPU_BASE, 25'h000_0000, SDRAM word base of CPU program ROM region
AUX_BASE, 25'h010_0000, SDRAM word base of auxiliary ROM region
AUX_AW, 20, auxiliary address width (words)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cpu_req  in  1  one-cycle strobe: CPU ROM read start (decode memrq qualified)
cpu_addr  in  20  translated CPU ROM word address
cpu_data  out  16  CPU read data, valid with cpu_ready
cpu_ready  out  1  one-cycle pulse: CPU read complete
inval  in  1  invalidate CPU hit buffer (bank register write)
aux_req  in  1  one-cycle strobe: aux read start
aux_addr  in  AUX_AW  aux word address
aux_data  out  16  aux read data, valid with aux_ack
aux_ack  out  1  one-cycle pulse: aux read complete
sdr_req  out  1  SDRAM read request, level, held until sdr_ack
sdr_addr  out  25  SDRAM word address, stable while sdr_req high
sdr_ack  in  1  one-cycle pulse: sdr_data valid, request done
sdr_data  in  16  SDRAM read data

Behaviour:
- One clock and one reset: clk, synchronous active-high reset.
- Reset values: sdr_req=0, sdr_addr=0, cpu_ready=0, aux_ack=0, cpu_data=0, aux_data=0.
- Reset also clears state=IDLE, cpu_pend=0, aux_pend=0, buf_valid=0 and last_owner=AUX, so the CPU wins the first tie.
- Request latching:
  - cpu_req sets cpu_pend and latches cpu_addr.
  - aux_req sets aux_pend and latches aux_addr.
  - A strobe while the same requester's pend=1 is ignored; the requester must wait for ready/ack.
- CPU hit:
  - Condition: cpu_req with buf_valid=1, cpu_addr==buf_addr and inval=0 in the same cycle.
  - Response: cpu_ready=1 and cpu_data=buf_data at the next cycle. cpu_pend is not set and there is no SDRAM access.
  - A hit is serviced in any state, including while an aux fetch is in flight.
- State machine, states IDLE, CPU_FETCH, AUX_FETCH:
  - IDLE, only cpu_pend set: go to CPU_FETCH; sdr_req=1, sdr_addr=CPU_BASE+cpu_addr (zero-extended).
  - IDLE, only aux_pend set: go to AUX_FETCH; sdr_req=1, sdr_addr=AUX_BASE+aux_addr.
  - IDLE, both set: round-robin; the requester that is not last_owner wins.
  - Pending flags are sampled in the cycle after the strobe, so a miss asserts sdr_req no earlier than strobe+1.
  - CPU_FETCH on sdr_ack: sdr_req=0, cpu_data=sdr_data, cpu_ready pulse, buf_addr=cpu latched addr, buf_data=sdr_data, buf_valid=1, cpu_pend=0, last_owner=CPU, go to IDLE.
  - AUX_FETCH on sdr_ack: sdr_req=0, aux_data=sdr_data, aux_ack pulse, aux_pend=0, last_owner=AUX, go to IDLE.
  - Back-to-back: from IDLE the next grant happens one cycle after the ack cycle. sdr_req is low for at least one cycle between requests.
- Latency:
  - Miss with SDRAM idle: sdr_req at N+1 for a strobe at N. Ack at M gives ready at M+1.
  - Hit: ready at N+1.
- sdr_ack while in IDLE, e.g. stale after reset, is ignored.
- inval:
  - Clears buf_valid the next cycle.
  - inval in the same cycle as a CPU fill ack: data is still returned, but buf_valid ends at 0 (inval wins).
- Address arithmetic: 25-bit, with wrap modulo 2^25 and no overflow detection.
- Reset mid-fetch: sdr_req drops the cycle after reset is sampled. Any pending request is discarded and no ready/ack is produced.

Decomposition:
- Add to board_pkg:
  - typedef enum rom_arb_state_t {IDLE, CPU_FETCH, AUX_FETCH}
  - typedef enum rom_owner_t {OWNER_CPU, OWNER_AUX}
  - localparam SDR_AW=25
- One natural sub-module: rom_hit_buffer, holding buf_addr, buf_data and buf_valid, with fill/invalidate/compare.

Test Plan:
- Reset, then cpu_req addr=20'h00123, sdr_ack 4 cycles after sdr_req with data 16'hBEEF -> sdr_addr=25'h0000123, cpu_ready one cycle after ack, cpu_data=16'hBEEF.
- Repeat cpu_req addr=20'h00123 -> cpu_ready at strobe+1 with 16'hBEEF, sdr_req stays 0; after inval, same address -> SDRAM fetch issued.
- cpu_req and aux_req (addr 20'h00010) in the same cycle after reset -> CPU granted first, then aux with sdr_addr=25'h0100010; next simultaneous pair -> CPU again (last_owner=AUX); then hold both pending across two grants -> alternation.
- Aux fetch in flight, cpu_req hit -> cpu_ready at strobe+1 while sdr_req stays high for aux; aux_ack follows its sdr_ack.
- inval in the same cycle as a CPU fill sdr_ack (data 16'h1234) -> cpu_data=16'h1234 returned, next identical cpu_req causes an SDRAM fetch.
- reset asserted while CPU_FETCH with sdr_req=1 -> sdr_req=0 next cycle; a late sdr_ack produces no cpu_ready/aux_ack.
